sequence_timing_controller: RTL
===============================

// Module: sequence_timing_controller
// PURPOSE
//  Owns the sequence counter (SC) and the instruction-field decode that feed the control unit.
//  - Generates the one-hot timing vector T[7:0].
//  - Latches the decoded opcode D[7:0], the indirect bit I and the register-reference field B[7:0].
//  - Runs a start/halt run-state machine and counts retired instructions.
//  - Sits between the IR and the control unit, and consumes that unit's SC-clear strobe.
// PARAMETERS
//  CNT_W   16  width of retired-instruction counter instr_count
//  SC_MAX  7   highest T index reachable; SC at SC_MAX without clr_sc triggers timeout (1..7)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      reset, synchronous, active-low
//  start        in   1      begin execution at T0 (ignored while running)
//  halt_req     in   1      stop at the next instruction boundary
//  clr_sc       in   1      SC clear strobe from control unit (end of instruction)
//  ir           in   8      IR contents: [7]=I, [6:4]=opcode, [3:0]=address/B field
//  T            out  8      one-hot timing, all-zero when not running
//  D            out  8      one-hot decode of ir[6:4], registered
//  I            out  1      registered ir[7]
//  B            out  8      {4'b0, ir[3:0]}, registered
//  running      out  1      1 in RUN state
//  instr_done   out  1      1-cycle pulse, cycle after a clr_sc accepted in RUN
//  instr_count  out  CNT_W  retired instructions, wraps at 2^CNT_W
//  timeout_err  out  1      sticky: SC reached SC_MAX with no clr_sc
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - state=IDLE; sc=0; T=0, D=0, I=0, B=0.
//   - running=0, instr_done=0, instr_count=0, timeout_err=0; halt_pending=0.
//  States: IDLE, RUN (plus STEP_WAIT when SINGLE_STEP_EN is defined).
//  IDLE:
//   - T=0; clr_sc ignored.
//   - start=1 -> RUN next cycle with sc=0, so T=8'h01 on the first RUN cycle.
//   - start also clears timeout_err and halt_pending, except as below.
//   - start and halt_req in the same cycle: start wins; halt_pending set; halts after the first instruction.
//  RUN:
//   - T = 1<<sc.
//   - Each cycle without clr_sc: sc<=sc+1.
//   - clr_sc=1: sc<=0; instr_done=1 next cycle; instr_count+1 on the same edge.
//   - clr_sc=1 with halt_pending (or halt_req this cycle): -> IDLE; halt_pending<=0; T=0 next cycle.
//   - halt_req without clr_sc: set halt_pending; the current instruction completes.
//   - sc==SC_MAX and clr_sc=0: sc<=0; timeout_err<=1; instr_count unchanged; instr_done stays 0.
//  Decode latch:
//   - On the edge where T[2]=1: D<=1<<ir[6:4], I<=ir[7], B<=ir[3:0].
//   - D/I/B are therefore valid from T3 and held until the next T2 capture.
//  clr_sc at T0..T2 is legal (SC resets); decode is not captured if T2 is never reached.
//  start while in RUN is ignored.
//  rst_n low mid-instruction: all state returns to reset values at that edge; no completion pulse.
//  Outputs are registered except T, which is decoded from registered sc and state.
// CONFIGURATION
//  SINGLE_STEP_EN defined:
//   - Adds inputs step_mode (1) and step (1).
//   - RUN with step_mode=1: an accepted clr_sc enters STEP_WAIT (T=0, running=1).
//   - STEP_WAIT: step=1 -> RUN at T0 next cycle.
//   - STEP_WAIT: halt_req=1 -> IDLE; halt has priority over step.
//  SINGLE_STEP_EN undefined: no step ports, no STEP_WAIT; RUN continues back-to-back.
// TESTING
//  1 rst_n=0 two cycles -> T=0, D=0, B=0, running=0, instr_count=0, timeout_err=0.
//  2 start, ir=8'h25 (LDA, I=0), clr_sc at T5 ->
//    - T=01,02,04,08,10,20 then 01; D=8'h04 and B=8'h05 from T3.
//    - instr_done pulses once; instr_count=1.
//  3 ir=8'h78 (register ref, I=0), clr_sc at T3 -> D=8'h80, I=0, B=8'h08; next cycle T=8'h01.
//  4 halt_req at T1 of an instruction, clr_sc at T4 -> instruction completes; next cycle running=0, T=0.
//  5 running, clr_sc never asserted -> T walks to 8'h80, then 8'h01; timeout_err=1; instr_count unchanged.
//  6 SINGLE_STEP_EN, step_mode=1 -> after clr_sc, T=0 until step; then T=8'h01; count advances by 1 per step.

Source files
------------

// File: rtl/sequence_timing_controller.sv
// Sequence counter, one-hot timing generator, IR field decode latch and run-state control.
// Optional single-step support is enabled by defining SINGLE_STEP_EN.
module sequence_timing_controller #(
    parameter int CNT_W  = 16,
    parameter int SC_MAX = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt_req,
    input  logic             clr_sc,
`ifdef SINGLE_STEP_EN
    input  logic             step_mode,
    input  logic             step,
`endif
    input  logic [7:0]       ir,
    output logic [7:0]       T,
    output logic [7:0]       D,
    output logic             I,
    output logic [7:0]       B,
    output logic             running,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count,
    output logic             timeout_err
);

`ifdef SINGLE_STEP_EN
    typedef enum logic [1:0] {IDLE, RUN, STEP_WAIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

    localparam logic [2:0]       SC_LAST  = 3'(SC_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [2:0]       sc_q, sc_d;
    logic             halt_pending_q, halt_pending_d;
    logic             running_q, running_d;
    logic             instr_done_q, instr_done_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic             timeout_q, timeout_d;
    logic [7:0]       d_q, d_d;
    logic             i_q, i_d;
    logic [3:0]       b_q, b_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            sc_q           <= 3'd0;
            halt_pending_q <= 1'b0;
            running_q      <= 1'b0;
            instr_done_q   <= 1'b0;
            instr_count_q  <= '0;
            timeout_q      <= 1'b0;
            d_q            <= 8'h00;
            i_q            <= 1'b0;
            b_q            <= 4'h0;
        end else begin
            state_q        <= state_d;
            sc_q           <= sc_d;
            halt_pending_q <= halt_pending_d;
            running_q      <= running_d;
            instr_done_q   <= instr_done_d;
            instr_count_q  <= instr_count_d;
            timeout_q      <= timeout_d;
            d_q            <= d_d;
            i_q            <= i_d;
            b_q            <= b_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        sc_d           = sc_q;
        halt_pending_d = halt_pending_q;
        instr_done_d   = 1'b0;
        instr_count_d  = instr_count_q;
        timeout_d      = timeout_q;
        d_d            = d_q;
        i_d            = i_q;
        b_d            = b_q;

        // Instruction fields are captured on the T2 edge even if clr_sc also arrives then.
        if (state_q == RUN && sc_q == 3'd2) begin
            d_d = 8'h01 << ir[6:4];
            i_d = ir[7];
            b_d = ir[3:0];
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d        = RUN;
                    sc_d           = 3'd0;
                    timeout_d      = 1'b0;
                    halt_pending_d = halt_req;
                end
            end
            RUN: begin
                if (clr_sc) begin
                    sc_d          = 3'd0;
                    instr_done_d  = 1'b1;
                    instr_count_d = instr_count_q + CNT_ONE;
                    if (halt_pending_q || halt_req) begin
                        state_d        = IDLE;
                        halt_pending_d = 1'b0;
`ifdef SINGLE_STEP_EN
                    end else if (step_mode) begin
                        state_d = STEP_WAIT;
`endif
                    end
                end else begin
                    if (halt_req)
                        halt_pending_d = 1'b1;
                    if (sc_q == SC_LAST) begin
                        sc_d      = 3'd0;
                        timeout_d = 1'b1;
                    end else begin
                        sc_d = sc_q + 3'd1;
                    end
                end
            end
`ifdef SINGLE_STEP_EN
            STEP_WAIT: begin
                if (halt_req) begin
                    state_d        = IDLE;
                    halt_pending_d = 1'b0;
                end else if (step) begin
                    state_d = RUN;
                    sc_d    = 3'd0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        running_d = (state_d != IDLE);
    end

    assign T           = (state_q == RUN) ? (8'h01 << sc_q) : 8'h00;
    assign D           = d_q;
    assign I           = i_q;
    assign B           = {4'h0, b_q};
    assign running     = running_q;
    assign instr_done  = instr_done_q;
    assign instr_count = instr_count_q;
    assign timeout_err = timeout_q;

endmodule
